control_pipeline: RTL and testbench
===================================

# control_pipeline

Pipelined control-word carrier and hazard unit for the 5-stage MIPS core. It takes the decoded control word from the ID-stage decoder plus the instruction's register fields. It registers them through the ID/EX, EX/MEM and MEM/WB stages. It also generates the load-use stall, the taken-branch flush and the EX-operand forwarding selects.

## Interface
Parameters:
- REG_W, 5, register-address width.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears every stage register.
- id_valid  in  1  ID holds a real instruction; 0 injects a bubble.
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_BranchEQ, id_BranchNE  in  1 each  decoded control bits. RegDst/MemtoReg may be X when RegWrite=0.
- id_ALUOp  in  4  decoded ALU operation.
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields.
- ex_branch_taken  in  1  EX-stage branch resolved taken (datapath computes from ex_BranchEQ/NE and zero flag).
- stall  out  1  combinational; freeze PC and IF/ID.
- flush_ifid  out  1  combinational; clear IF/ID.
- ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_BranchEQ, ex_BranchNE  out  1 each  ID/EX control.
- ex_ALUOp  out  4  ID/EX ALU operation.
- ex_write_reg  out  REG_W  destination chosen at ID/EX load.
- mem_MemtoReg, mem_RegWrite, mem_MemRead, mem_MemWrite  out  1 each  EX/MEM control.
- mem_write_reg  out  REG_W.
- wb_MemtoReg, wb_RegWrite  out  1 each  MEM/WB control.
- wb_write_reg  out  REG_W.
- forward_a, forward_b  out  2  combinational EX operand selects: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.

## Operation
- Internal ID/EX also holds ex_rs, ex_rt (not exported).
- ID/EX load value:
  - Normal: id_* fields, with ex_write_reg = id_RegDst ? id_rd : id_rt.
  - Bubble: all control bits 0, ALUOp 0, registers 0.
- Bubble is loaded when any of these holds: id_valid=0, stall=1, or ex_branch_taken=1.
- EX/MEM always loads from ID/EX. MEM/WB always loads from EX/MEM. Stall does not freeze EX/MEM or MEM/WB.
- Load-use hazard: hz = ex_MemRead & (ex_write_reg != 0) & id_valid & (ex_write_reg == id_rs | ex_write_reg == id_rt).
- stall = hz & ~ex_branch_taken. A taken branch cancels the stalled instruction, so flush wins.
- flush_ifid = ex_branch_taken.
- forward_a:
  - 10 if mem_RegWrite & mem_write_reg != 0 & mem_write_reg == ex_rs;
  - else 01 if wb_RegWrite & wb_write_reg != 0 & wb_write_reg == ex_rs;
  - else 00.
- forward_b: same rule against ex_rt.
- Priority: EX/MEM over MEM/WB (newest value wins).
- Register 0 never forwards and never causes a stall.
- X on RegDst/MemtoReg with RegWrite=0 must not reach stall/forward outputs. All comparisons are qualified by RegWrite/MemRead.

## Timing
- Reset (asynchronous assert, synchronous release on next edge): all stage registers 0. All ex_/mem_/wb_ outputs are 0, stall=0, flush_ifid=0, forward_a=forward_b=00.
- Control word presented in ID at edge n appears on ex_* after edge n, mem_* after n+1, wb_* after n+2.
- Load-use costs exactly one bubble cycle. The stalled instruction re-presents next cycle with hz=0, because the load is now in MEM.
- Branch taken in cycle n: flush_ifid=1 and stall=0 in cycle n. ex_* is a bubble after edge n. The instruction in IF/ID is discarded by the datapath.
- Reset asserted mid-operation clears all stages immediately. In-flight instructions are lost; no partial write is signalled.

## Test plan
- Reset: hold reset=0 with id_valid=1 and an ADDI word. All outputs stay 0. Release; the word appears on ex_* one edge later.
- Propagation: R-type rd=3 at cycle 0. ex_write_reg=3, ex_ALUOp=0000 at cycle 1; mem_RegWrite=1 at cycle 2; wb_RegWrite=1, wb_write_reg=3 at cycle 3. Then bubble.
- Load-use: LW rt=5, then ADD rs=5. stall=1 for one cycle and ex_* is a bubble. The ADD enters EX the following cycle with forward_a=01.
- Forwarding priority:
  - ADDI rt=7, ADDI rt=7, then ADD rs=7 rt=7: ADD in EX sees forward_a=forward_b=10.
  - Same sequence with the second ADDI replaced by a bubble: 01.
  - Any destination 0: 00.
- Branch flush: BEQ in EX with ex_branch_taken=1 while a stall condition is also present. flush_ifid=1, stall=0, and the next ex_* is a bubble.
- Mid-operation reset: pulse reset low for half a cycle with a LW in MEM. mem_MemRead drops to 0 immediately and all later stages hold 0.

Source files
------------

// File: rtl/control_pipeline_if.sv
// Control/hazard bundle between the MIPS ID/EX datapath and control_pipeline.
// The datapath drives id_* and ex_branch_taken; control_pipeline drives everything else.
interface control_pipeline_if #(
   parameter int unsigned REG_W = 5
);
   logic             id_valid;
   logic             id_RegDst;
   logic             id_ALUSrc;
   logic             id_MemtoReg;
   logic             id_RegWrite;
   logic             id_MemRead;
   logic             id_MemWrite;
   logic             id_BranchEQ;
   logic             id_BranchNE;
   logic [3:0]       id_ALUOp;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic [REG_W-1:0] id_rd;
   logic             ex_branch_taken;

   logic             stall;
   logic             flush_ifid;
   logic             ex_RegDst;
   logic             ex_ALUSrc;
   logic             ex_MemtoReg;
   logic             ex_RegWrite;
   logic             ex_MemRead;
   logic             ex_MemWrite;
   logic             ex_BranchEQ;
   logic             ex_BranchNE;
   logic [3:0]       ex_ALUOp;
   logic [REG_W-1:0] ex_write_reg;
   logic             mem_MemtoReg;
   logic             mem_RegWrite;
   logic             mem_MemRead;
   logic             mem_MemWrite;
   logic [REG_W-1:0] mem_write_reg;
   logic             wb_MemtoReg;
   logic             wb_RegWrite;
   logic [REG_W-1:0] wb_write_reg;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;

   modport master (
      output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
             id_MemWrite, id_BranchEQ, id_BranchNE, id_ALUOp, id_rs, id_rt, id_rd,
             ex_branch_taken,
      input  stall, flush_ifid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_BranchEQ, ex_BranchNE, ex_ALUOp, ex_write_reg, mem_MemtoReg,
             mem_RegWrite, mem_MemRead, mem_MemWrite, mem_write_reg, wb_MemtoReg,
             wb_RegWrite, wb_write_reg, forward_a, forward_b
   );

   modport slave (
      input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
             id_MemWrite, id_BranchEQ, id_BranchNE, id_ALUOp, id_rs, id_rt, id_rd,
             ex_branch_taken,
      output stall, flush_ifid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_BranchEQ, ex_BranchNE, ex_ALUOp, ex_write_reg, mem_MemtoReg,
             mem_RegWrite, mem_MemRead, mem_MemWrite, mem_write_reg, wb_MemtoReg,
             wb_RegWrite, wb_write_reg, forward_a, forward_b
   );
endinterface

// File: rtl/control_pipeline.sv
// Pipelined control-word carrier (ID/EX, EX/MEM, MEM/WB) and hazard unit for the
// 5-stage MIPS core: load-use stall, taken-branch flush and EX operand forwarding.
module control_pipeline #(
   parameter int unsigned REG_W = 5
) (
   input logic               clk,
   input logic               reset,
   control_pipeline_if.slave cp_if
);

   logic             r_ex_regdst;
   logic             r_ex_alusrc;
   logic             r_ex_memtoreg;
   logic             r_ex_regwrite;
   logic             r_ex_memread;
   logic             r_ex_memwrite;
   logic             r_ex_beq;
   logic             r_ex_bne;
   logic [3:0]       r_ex_aluop;
   logic [REG_W-1:0] r_ex_write_reg;
   logic [REG_W-1:0] r_ex_rs;
   logic [REG_W-1:0] r_ex_rt;

   logic             r_mem_memtoreg;
   logic             r_mem_regwrite;
   logic             r_mem_memread;
   logic             r_mem_memwrite;
   logic [REG_W-1:0] r_mem_write_reg;

   logic             r_wb_memtoreg;
   logic             r_wb_regwrite;
   logic [REG_W-1:0] r_wb_write_reg;

   logic             w_hz;
   logic             w_stall;
   logic             w_bubble;
   logic [REG_W-1:0] w_id_write_reg;
   logic             w_mem_fwd_ok;
   logic             w_wb_fwd_ok;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   // Every term is gated by MemRead/RegWrite so an X destination on a non-writing
   // instruction cannot leak into stall or forward selects.
   assign w_hz = r_ex_memread & (r_ex_write_reg != '0) & cp_if.id_valid &
                 ((r_ex_write_reg == cp_if.id_rs) | (r_ex_write_reg == cp_if.id_rt));
   assign w_stall        = w_hz & ~cp_if.ex_branch_taken;
   assign w_bubble       = ~cp_if.id_valid | w_stall | cp_if.ex_branch_taken;
   assign w_id_write_reg = cp_if.id_RegDst ? cp_if.id_rd : cp_if.id_rt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_regdst    <= 1'b0;
         r_ex_alusrc    <= 1'b0;
         r_ex_memtoreg  <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_ex_memwrite  <= 1'b0;
         r_ex_beq       <= 1'b0;
         r_ex_bne       <= 1'b0;
         r_ex_aluop     <= '0;
         r_ex_write_reg <= '0;
         r_ex_rs        <= '0;
         r_ex_rt        <= '0;
      end else if (w_bubble) begin
         r_ex_regdst    <= 1'b0;
         r_ex_alusrc    <= 1'b0;
         r_ex_memtoreg  <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_ex_memwrite  <= 1'b0;
         r_ex_beq       <= 1'b0;
         r_ex_bne       <= 1'b0;
         r_ex_aluop     <= '0;
         r_ex_write_reg <= '0;
         r_ex_rs        <= '0;
         r_ex_rt        <= '0;
      end else begin
         r_ex_regdst    <= cp_if.id_RegDst;
         r_ex_alusrc    <= cp_if.id_ALUSrc;
         r_ex_memtoreg  <= cp_if.id_MemtoReg;
         r_ex_regwrite  <= cp_if.id_RegWrite;
         r_ex_memread   <= cp_if.id_MemRead;
         r_ex_memwrite  <= cp_if.id_MemWrite;
         r_ex_beq       <= cp_if.id_BranchEQ;
         r_ex_bne       <= cp_if.id_BranchNE;
         r_ex_aluop     <= cp_if.id_ALUOp;
         r_ex_write_reg <= w_id_write_reg;
         r_ex_rs        <= cp_if.id_rs;
         r_ex_rt        <= cp_if.id_rt;
      end
   end

   // Later stages never freeze: a stall only inserts a bubble at ID/EX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem_memtoreg  <= 1'b0;
         r_mem_regwrite  <= 1'b0;
         r_mem_memread   <= 1'b0;
         r_mem_memwrite  <= 1'b0;
         r_mem_write_reg <= '0;
         r_wb_memtoreg   <= 1'b0;
         r_wb_regwrite   <= 1'b0;
         r_wb_write_reg  <= '0;
      end else begin
         r_mem_memtoreg  <= r_ex_memtoreg;
         r_mem_regwrite  <= r_ex_regwrite;
         r_mem_memread   <= r_ex_memread;
         r_mem_memwrite  <= r_ex_memwrite;
         r_mem_write_reg <= r_ex_write_reg;
         r_wb_memtoreg   <= r_mem_memtoreg;
         r_wb_regwrite   <= r_mem_regwrite;
         r_wb_write_reg  <= r_mem_write_reg;
      end
   end

   assign w_mem_fwd_ok = r_mem_regwrite & (r_mem_write_reg != '0);
   assign w_wb_fwd_ok  = r_wb_regwrite & (r_wb_write_reg != '0);

   // EX/MEM is checked first so the newest producer wins.
   always_comb begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
      if (w_mem_fwd_ok && (r_mem_write_reg == r_ex_rs)) begin
         w_fwd_a = 2'b10;
      end else if (w_wb_fwd_ok && (r_wb_write_reg == r_ex_rs)) begin
         w_fwd_a = 2'b01;
      end
      if (w_mem_fwd_ok && (r_mem_write_reg == r_ex_rt)) begin
         w_fwd_b = 2'b10;
      end else if (w_wb_fwd_ok && (r_wb_write_reg == r_ex_rt)) begin
         w_fwd_b = 2'b01;
      end
   end

   assign cp_if.stall         = w_stall;
   assign cp_if.flush_ifid    = cp_if.ex_branch_taken;
   assign cp_if.forward_a     = w_fwd_a;
   assign cp_if.forward_b     = w_fwd_b;

   assign cp_if.ex_RegDst     = r_ex_regdst;
   assign cp_if.ex_ALUSrc     = r_ex_alusrc;
   assign cp_if.ex_MemtoReg   = r_ex_memtoreg;
   assign cp_if.ex_RegWrite   = r_ex_regwrite;
   assign cp_if.ex_MemRead    = r_ex_memread;
   assign cp_if.ex_MemWrite   = r_ex_memwrite;
   assign cp_if.ex_BranchEQ   = r_ex_beq;
   assign cp_if.ex_BranchNE   = r_ex_bne;
   assign cp_if.ex_ALUOp      = r_ex_aluop;
   assign cp_if.ex_write_reg  = r_ex_write_reg;

   assign cp_if.mem_MemtoReg  = r_mem_memtoreg;
   assign cp_if.mem_RegWrite  = r_mem_regwrite;
   assign cp_if.mem_MemRead   = r_mem_memread;
   assign cp_if.mem_MemWrite  = r_mem_memwrite;
   assign cp_if.mem_write_reg = r_mem_write_reg;

   assign cp_if.wb_MemtoReg   = r_wb_memtoreg;
   assign cp_if.wb_RegWrite   = r_wb_regwrite;
   assign cp_if.wb_write_reg  = r_wb_write_reg;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: directed scenarios plus random instruction streams,
// checked against a three-slot instruction-record pipeline model.
module tb_control_pipeline;

   localparam int K_R    = 0;
   localparam int K_ADDI = 1;
   localparam int K_LW   = 2;
   localparam int K_SW   = 3;
   localparam int K_BEQ  = 4;
   localparam int K_BNE  = 5;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       beq;
      logic       bne;
      logic [3:0] aluop;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] wreg;
   } rec_t;

   logic clk;
   logic reset;

   control_pipeline_if #(.REG_W(5)) cp ();

   control_pipeline #(.REG_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .cp_if (cp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests;
   int   n_fail;
   rec_t m_ex, m_mem, m_wb;
   rec_t cur;
   rec_t nop;
   rec_t pend;
   logic cur_valid;
   logic taken;
   logic last_stall;
   logic pv;
   logic tk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
      rec_t r;
      r    = '0;
      r.rs = rs;
      r.rt = rt;
      r.rd = rd;
      case (kind)
         K_R:    begin r.regdst = 1'b1; r.regwrite = 1'b1; r.aluop = 4'b0000; end
         K_ADDI: begin r.alusrc = 1'b1; r.regwrite = 1'b1; r.aluop = 4'b0001; end
         K_LW: begin
            r.alusrc = 1'b1; r.memtoreg = 1'b1; r.regwrite = 1'b1; r.memread = 1'b1;
            r.aluop  = 4'b0010;
         end
         K_SW: begin
            r.alusrc = 1'b1; r.memwrite = 1'b1; r.aluop = 4'b0010;
            r.regdst = 1'($urandom_range(0, 1)); r.memtoreg = 1'($urandom_range(0, 1));
         end
         K_BEQ: begin
            r.beq = 1'b1; r.aluop = 4'b0110;
            r.regdst = 1'($urandom_range(0, 1)); r.memtoreg = 1'($urandom_range(0, 1));
         end
         default: begin
            r.bne = 1'b1; r.aluop = 4'b0110;
            r.regdst = 1'($urandom_range(0, 1)); r.memtoreg = 1'($urandom_range(0, 1));
         end
      endcase
      return r;
   endfunction

   // Destination is chosen when the word enters EX.
   function automatic rec_t load(input rec_t r);
      rec_t x;
      x      = r;
      x.wreg = r.regdst ? r.rd : r.rt;
      return x;
   endfunction

   function automatic logic load_writes(input logic [4:0] r);
      return m_ex.memread && (m_ex.wreg != 5'd0) && (m_ex.wreg == r);
   endfunction

   function automatic logic exp_stall();
      return cur_valid && (load_writes(cur.rs) || load_writes(cur.rt)) && !taken;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] r);
      if (r == 5'd0) return 2'b00;
      if (m_mem.regwrite && m_mem.wreg == r) return 2'b10;
      if (m_wb.regwrite && m_wb.wreg == r) return 2'b01;
      return 2'b00;
   endfunction

   task automatic drive(input rec_t r, input logic v, input logic t);
      cur                = r;
      cur_valid          = v;
      taken              = t;
      cp.id_valid        = v;
      cp.id_RegDst       = r.regdst;
      cp.id_ALUSrc       = r.alusrc;
      cp.id_MemtoReg     = r.memtoreg;
      cp.id_RegWrite     = r.regwrite;
      cp.id_MemRead      = r.memread;
      cp.id_MemWrite     = r.memwrite;
      cp.id_BranchEQ     = r.beq;
      cp.id_BranchNE     = r.bne;
      cp.id_ALUOp        = r.aluop;
      cp.id_rs           = r.rs;
      cp.id_rt           = r.rt;
      cp.id_rd           = r.rd;
      cp.ex_branch_taken = t;
   endtask

   task automatic check_all();
      check("stall", 32'(cp.stall), 32'(exp_stall()));
      check("flush_ifid", 32'(cp.flush_ifid), 32'(taken));
      check("forward_a", 32'(cp.forward_a), 32'(exp_fwd(m_ex.rs)));
      check("forward_b", 32'(cp.forward_b), 32'(exp_fwd(m_ex.rt)));
      check("ex_word",
            32'({cp.ex_RegDst, cp.ex_ALUSrc, cp.ex_MemtoReg, cp.ex_RegWrite, cp.ex_MemRead,
                 cp.ex_MemWrite, cp.ex_BranchEQ, cp.ex_BranchNE, cp.ex_ALUOp, cp.ex_write_reg}),
            32'({m_ex.regdst, m_ex.alusrc, m_ex.memtoreg, m_ex.regwrite, m_ex.memread,
                 m_ex.memwrite, m_ex.beq, m_ex.bne, m_ex.aluop, m_ex.wreg}));
      check("mem_word",
            32'({cp.mem_MemtoReg, cp.mem_RegWrite, cp.mem_MemRead, cp.mem_MemWrite,
                 cp.mem_write_reg}),
            32'({m_mem.memtoreg, m_mem.regwrite, m_mem.memread, m_mem.memwrite, m_mem.wreg}));
      check("wb_word", 32'({cp.wb_MemtoReg, cp.wb_RegWrite, cp.wb_write_reg}),
            32'({m_wb.memtoreg, m_wb.regwrite, m_wb.wreg}));
   endtask

   // Check at the falling edge, predict the next model state, then step over the rising edge.
   task automatic cycle();
      rec_t n_ex, n_mem, n_wb;
      @(negedge clk);
      check_all();
      last_stall = exp_stall();
      if (!reset) begin
         n_ex  = '0;
         n_mem = '0;
         n_wb  = '0;
      end else begin
         n_wb  = m_mem;
         n_mem = m_ex;
         n_ex  = (!cur_valid || last_stall || taken) ? '0 : load(cur);
      end
      @(posedge clk);
      m_ex  = n_ex;
      m_mem = n_mem;
      m_wb  = n_wb;
      #1;
   endtask

   task automatic drain();
      drive(nop, 1'b0, 1'b0);
      repeat (3) cycle();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      m_ex       = '0;
      m_mem      = '0;
      m_wb       = '0;
      nop        = '0;
      last_stall = 1'b0;
      reset      = 1'b0;

      // Reset held with a live ADDI in ID.
      drive(mk(K_ADDI, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0);
      repeat (3) cycle();
      check("rst_ex_regwrite", 32'(cp.ex_RegWrite), 32'd0);
      check("rst_ex_write_reg", 32'(cp.ex_write_reg), 32'd0);
      reset = 1'b1;
      cycle();
      check("rel_ex_write_reg", 32'(cp.ex_write_reg), 32'd2);
      check("rel_ex_alusrc", 32'(cp.ex_ALUSrc), 32'd1);
      drain();

      // Propagation of an R-type through the three stages.
      drive(mk(K_R, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
      cycle();
      check("prop_ex_write_reg", 32'(cp.ex_write_reg), 32'd3);
      check("prop_ex_aluop", 32'(cp.ex_ALUOp), 32'd0);
      drive(nop, 1'b0, 1'b0);
      cycle();
      check("prop_mem_regwrite", 32'(cp.mem_RegWrite), 32'd1);
      check("prop_ex_bubble", 32'(cp.ex_RegWrite), 32'd0);
      cycle();
      check("prop_wb_regwrite", 32'(cp.wb_RegWrite), 32'd1);
      check("prop_wb_write_reg", 32'(cp.wb_write_reg), 32'd3);
      drain();

      // Load-use: one bubble, then the ADD takes the loaded value from MEM/WB.
      drive(mk(K_LW, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
      cycle();
      drive(mk(K_R, 5'd5, 5'd2, 5'd6), 1'b1, 1'b0);
      #1;
      check("lu_stall", 32'(cp.stall), 32'd1);
      cycle();
      check("lu_ex_bubble", 32'(cp.ex_RegWrite), 32'd0);
      check("lu_stall_clear", 32'(cp.stall), 32'd0);
      cycle();
      check("lu_fwd_a", 32'(cp.forward_a), 32'd1);
      check("lu_ex_write_reg", 32'(cp.ex_write_reg), 32'd6);
      drain();

      // Forwarding priority: EX/MEM over MEM/WB, register 0 never forwards.
      drive(mk(K_ADDI, 5'd1, 5'd7, 5'd0), 1'b1, 1'b0);
      cycle();
      cycle();
      drive(mk(K_R, 5'd7, 5'd7, 5'd8), 1'b1, 1'b0);
      cycle();
      check("fwd_a_exmem", 32'(cp.forward_a), 32'd2);
      check("fwd_b_exmem", 32'(cp.forward_b), 32'd2);
      drain();
      drive(mk(K_ADDI, 5'd1, 5'd7, 5'd0), 1'b1, 1'b0);
      cycle();
      drive(nop, 1'b0, 1'b0);
      cycle();
      drive(mk(K_R, 5'd7, 5'd7, 5'd8), 1'b1, 1'b0);
      cycle();
      check("fwd_a_memwb", 32'(cp.forward_a), 32'd1);
      check("fwd_b_memwb", 32'(cp.forward_b), 32'd1);
      drain();
      drive(mk(K_ADDI, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0);
      cycle();
      cycle();
      drive(mk(K_R, 5'd0, 5'd0, 5'd8), 1'b1, 1'b0);
      cycle();
      check("fwd_a_r0", 32'(cp.forward_a), 32'd0);
      check("fwd_b_r0", 32'(cp.forward_b), 32'd0);
      drain();

      // Taken branch while a load-use condition is also present: flush wins.
      drive(mk(K_LW, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
      cycle();
      drive(mk(K_R, 5'd5, 5'd2, 5'd6), 1'b1, 1'b1);
      #1;
      check("br_flush", 32'(cp.flush_ifid), 32'd1);
      check("br_stall", 32'(cp.stall), 32'd0);
      cycle();
      check("br_ex_bubble", 32'(cp.ex_RegWrite), 32'd0);
      check("br_ex_write_reg", 32'(cp.ex_write_reg), 32'd0);
      drain();

      // Asynchronous reset with a load in MEM.
      drive(mk(K_LW, 5'd1, 5'd9, 5'd0), 1'b1, 1'b0);
      cycle();
      drive(nop, 1'b0, 1'b0);
      cycle();
      check("mr_pre_memread", 32'(cp.mem_MemRead), 32'd1);
      reset = 1'b0;
      #2;
      check("mr_memread", 32'(cp.mem_MemRead), 32'd0);
      check("mr_mem_regwrite", 32'(cp.mem_RegWrite), 32'd0);
      check("mr_wb_regwrite", 32'(cp.wb_RegWrite), 32'd0);
      check("mr_mem_write_reg", 32'(cp.mem_write_reg), 32'd0);
      #1;
      reset = 1'b1;
      m_ex  = '0;
      m_mem = '0;
      m_wb  = '0;
      drain();

      // Random streams; a stalled instruction is re-presented as the datapath would.
      pend = nop;
      pv   = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            pend = mk(int'($urandom_range(0, 5)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            pv   = ($urandom_range(0, 7) != 0);
         end
         tk = (m_ex.beq || m_ex.bne) && ($urandom_range(0, 1) == 1);
         drive(pend, pv, tk);
         cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
